// File: rtl/config_loader_pkg.sv
// Shared encodings and defaults for the serial configuration loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LENGTH = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [3:0] PREAMBLE      = 4'b0010;
  localparam int         LEN_W_DEF     = 24;
  localparam int         CHAIN_LEN_DEF = 12038;

endpackage

// File: rtl/config_loader_cfg_bit_counter.sv
// Loadable down-counter with a zero flag; shared by the length-field and data-bit counts.
module cfg_bit_counter #(
  parameter int LEN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/config_loader.sv
// Serial bitstream loader: preamble detect, length count, chain shifting, parity check and
// daisy-chain passthrough once configuration is done.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic shift_clk,
  input  logic rst_n,
  input  logic prog_n,
  input  logic din,
  input  logic din_valid,
  output logic shift_en,
  output logic shift_o,
  output logic dout,
  output logic dout_valid,
  output logic busy,
  output logic done,
  output logic error
);

  state_t           state;
  logic [3:0]       window;
  logic [LEN_W-1:0] len_sr;
  logic [LEN_W-1:0] len_next;
  logic             len_ok;
  logic             preamble_hit;
  logic             parity;
  logic             cnt_load;
  logic [LEN_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign len_next     = {len_sr[LEN_W-2:0], din};
  assign len_ok       = (len_next != '0) && (len_next <= LEN_W'(CHAIN_LEN));
  assign preamble_hit = ({window[2:0], din} == PREAMBLE);

  // The counter counts remaining bits minus one, so zero marks the last bit of a field.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (prog_n && din_valid) begin
      case (state)
        ST_IDLE: begin
          if (preamble_hit) begin
            cnt_load = 1'b1;
            cnt_val  = LEN_W'(LEN_W - 1);
          end
        end
        ST_LENGTH: begin
          if (cnt_zero) begin
            cnt_load = len_ok;
            cnt_val  = len_next - 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_DATA: cnt_dec = !cnt_zero;
        default: ;
      endcase
    end
  end

  cfg_bit_counter #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk      (shift_clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge shift_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      window     <= 4'b1111;
      len_sr     <= '0;
      parity     <= 1'b0;
      shift_en   <= 1'b0;
      shift_o    <= 1'b0;
      dout       <= 1'b1;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      dout_valid <= 1'b0;
      // A restart drops any bit presented in the same cycle.
      if (!prog_n) begin
        state  <= ST_IDLE;
        window <= 4'b1111;
        dout   <= 1'b1;
        busy   <= 1'b0;
        done   <= 1'b0;
        error  <= 1'b0;
      end else if (din_valid) begin
        case (state)
          ST_IDLE: begin
            window <= {window[2:0], din};
            if (preamble_hit) begin
              state <= ST_LENGTH;
              busy  <= 1'b1;
            end
          end
          ST_LENGTH: begin
            len_sr <= len_next;
            if (cnt_zero) begin
              if (len_ok) begin
                state  <= ST_DATA;
                parity <= 1'b0;
              end else begin
                state <= ST_ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            shift_o  <= din;
            shift_en <= 1'b1;
            parity   <= parity ^ din;
            if (cnt_zero) state <= ST_PARITY;
          end
          ST_PARITY: begin
            busy <= 1'b0;
            if ((parity ^ din) == 1'b0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
          ST_DONE: begin
            dout       <= din;
            dout_valid <= 1'b1;
          end
          ST_ERROR: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: expected chain and daisy-chain bits are queued as driven.
module tb_config_loader;

  localparam int LEN_W     = 24;
  localparam int CHAIN_LEN = 12038;

  logic shift_clk = 1'b0;
  logic rst_n     = 1'b0;
  logic prog_n    = 1'b1;
  logic din       = 1'b0;
  logic din_valid = 1'b0;
  logic shift_en, shift_o, dout, dout_valid, busy, done, error;

  int   n_chk = 0;
  int   n_err = 0;
  bit   sq[$];
  bit   dq[$];
  bit   gap = 1'b0;
  logic vld_edge = 1'b0;

  config_loader #(
    .LEN_W    (LEN_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .shift_clk (shift_clk),
    .rst_n     (rst_n),
    .prog_n    (prog_n),
    .din       (din),
    .din_valid (din_valid),
    .shift_en  (shift_en),
    .shift_o   (shift_o),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 shift_clk = ~shift_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge shift_clk) vld_edge <= din_valid & prog_n;

  always @(negedge shift_clk) begin
    if (rst_n) begin
      if (shift_en) begin
        chk("shift_en_after_valid", vld_edge, 1);
        if (sq.size() == 0) chk("shift_en_extra", 1, 0);
        else chk("shift_o", shift_o, sq.pop_front());
      end
      if (dout_valid) begin
        chk("dout_after_valid", vld_edge, 1);
        if (dq.size() == 0) chk("dout_valid_extra", 1, 0);
        else chk("dout", dout, dq.pop_front());
      end
    end
  end

  task automatic send(input bit b);
    @(negedge shift_clk);
    din       = b;
    din_valid = 1'b1;
    if (gap) begin
      @(negedge shift_clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge shift_clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic send_header(input int len);
    logic [LEN_W-1:0] lv;
    lv = LEN_W'(len);
    repeat (4) send(1'b1);
    send(1'b0); send(1'b0); send(1'b1); send(1'b0);
    for (int i = LEN_W - 1; i >= 0; i--) send(lv[i]);
  endtask

  task automatic send_data(input bit d[$], input bit push);
    foreach (d[i]) begin
      if (push) sq.push_back(d[i]);
      send(d[i]);
    end
  endtask

  task automatic do_prog();
    @(negedge shift_clk);
    prog_n    = 1'b0;
    din_valid = 1'b0;
    @(negedge shift_clk);
    prog_n = 1'b1;
    chk("prog_busy", busy, 0);
    chk("prog_done", done, 0);
    chk("prog_error", error, 0);
    chk("prog_dout", dout, 1);
  endtask

  bit d5[$];
  bit dbig[$];
  bit pbig;

  initial begin
    d5 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge shift_clk);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_shift_o", shift_o, 0);
    chk("rst_dout", dout, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    idle(2);

    // Nominal load with good parity, then daisy-chain passthrough.
    send_header(5);
    idle(1);
    chk("busy_after_len", busy, 1);
    send_data(d5, 1'b1);
    send(1'b1);
    idle(1);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_busy", busy, 0);
    chk("t1_sb_empty", sq.size(), 0);
    dq.push_back(1'b1); send(1'b1);
    dq.push_back(1'b0); send(1'b0);
    dq.push_back(1'b1); send(1'b1);
    idle(2);
    chk("t5_dq_empty", dq.size(), 0);
    chk("t5_dout_hold", dout, 1);
    chk("t5_dout_valid_low", dout_valid, 0);
    do_prog();

    // Bad parity: error, and no passthrough afterwards.
    send_header(5);
    send_data(d5, 1'b1);
    send(1'b0);
    idle(1);
    chk("t2_error", error, 1);
    chk("t2_done", done, 0);
    chk("t2_sb_empty", sq.size(), 0);
    send(1'b1); send(1'b0); send(1'b1);
    idle(2);
    chk("t2_error_sticky", error, 1);
    do_prog();

    // Illegal lengths: zero and one past the chain length.
    send_header(0);
    idle(1);
    chk("t3_len0_error", error, 1);
    chk("t3_len0_busy", busy, 0);
    send(1'b1); send(1'b0); send(1'b1);
    idle(2);
    do_prog();
    send_header(CHAIN_LEN + 1);
    idle(1);
    chk("t3_lenmax_error", error, 1);
    chk("t3_lenmax_done", done, 0);
    send(1'b1); send(1'b1);
    idle(2);
    do_prog();

    // Longest legal length with random data.
    pbig = 1'b0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      dbig.push_back(1'($urandom_range(0, 1)));
      pbig ^= dbig[i];
    end
    send_header(CHAIN_LEN);
    send_data(dbig, 1'b1);
    send(pbig);
    idle(1);
    chk("tmax_done", done, 1);
    chk("tmax_sb_empty", sq.size(), 0);
    do_prog();

    // Gapped din_valid through the nominal stream.
    gap = 1'b1;
    send_header(5);
    send_data(d5, 1'b1);
    send(1'b1);
    idle(1);
    gap = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_sb_empty", sq.size(), 0);
    do_prog();

    // Restart mid-DATA coinciding with a valid bit.
    send_header(5);
    send_data('{1'b1, 1'b0}, 1'b1);
    @(negedge shift_clk);
    chk("t6_busy_data", busy, 1);
    din       = 1'b1;
    din_valid = 1'b1;
    prog_n    = 1'b0;
    @(negedge shift_clk);
    prog_n    = 1'b0;
    din_valid = 1'b0;
    chk("t6_shift_en_dropped", shift_en, 0);
    chk("t6_busy", busy, 0);
    prog_n = 1'b1;
    chk("t6_sb_empty", sq.size(), 0);
    send_header(5);
    send_data(d5, 1'b1);
    send(1'b1);
    idle(1);
    chk("t6_done", done, 1);
    chk("t6_error", error, 0);
    chk("t6_sb_final", sq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
